// File: rtl/bearing_pkg.sv
// rtl/bearing_pkg.sv - shared types and constants for the bearing sequencer
package bearing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_RESOLVE,
    ST_CHECK,
    ST_OUTPUT,
    ST_FAIL
  } state_e;

  localparam logic [8:0] INVALID_THETA = 9'h1FF;
  localparam logic [8:0] THETA_MAX     = 9'd359;

  function automatic logic theta_ok(input logic [8:0] theta);
    return (theta != INVALID_THETA) && (theta <= THETA_MAX);
  endfunction

endpackage

// File: rtl/bearing_code_latch.sv
// rtl/bearing_code_latch.sv - 8-bit sticky code register; first strobe after clear wins
module bearing_code_latch (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear_i,
  input  logic       strobe_i,
  input  logic [7:0] code_i,
  output logic [7:0] code_o,
  output logic       latched_o
);

  logic [7:0] code_q;
  logic       latched_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      code_q    <= 8'd0;
      latched_q <= 1'b0;
    end else if (clear_i) begin
      code_q    <= 8'd0;
      latched_q <= 1'b0;
    end else if (strobe_i && !latched_q) begin
      code_q    <= code_i;
      latched_q <= 1'b1;
    end
  end

  assign code_o    = code_q;
  assign latched_o = latched_q;

endmodule

// File: rtl/bearing_sequencer.sv
// rtl/bearing_sequencer.sv - arm/capture/resolve/check sequencer for one bearing measurement
// Optional CAPTURE watchdog enabled by defining BEARING_TIMEOUT_EN.
module bearing_sequencer
  import bearing_pkg::*;
#(
  parameter int          RES_LATENCY    = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter int          MAX_RETRY      = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] code_valid,
  input  logic [7:0] code_x1,
  input  logic [7:0] code_x2,
  input  logic [7:0] code_y1,
  input  logic [7:0] code_y2,
  output logic       arm,
  output logic [7:0] res_code_x1,
  output logic [7:0] res_code_x2,
  output logic [7:0] res_code_y1,
  output logic [7:0] res_code_y2,
  input  logic [8:0] res_theta,
  output logic [8:0] theta_out,
  output logic       theta_valid,
  input  logic       theta_ready,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] RES_LAST    = 8'(RES_LATENCY - 1);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  state_e     state_q, state_d;
  logic [3:0] retry_q, retry_d;
  logic       err_q, err_d;
  logic [8:0] theta_q, theta_d;
  logic [7:0] res_cnt_q, res_cnt_d;
  logic [7:0] res_q [4];
  logic       load_res, latch_clear, check_good;

  logic [7:0] chan_code [4];
  logic [7:0] chan_q    [4];
  logic [3:0] chan_latched;

  assign chan_code[0] = code_x1;
  assign chan_code[1] = code_x2;
  assign chan_code[2] = code_y1;
  assign chan_code[3] = code_y2;

  for (genvar i = 0; i < 4; i++) begin : g_latch
    bearing_code_latch u_latch (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear_i  (latch_clear),
      .strobe_i (code_valid[i] && (state_q == ST_CAPTURE)),
      .code_i   (chan_code[i]),
      .code_o   (chan_q[i]),
      .latched_o(chan_latched[i])
    );
  end

`ifdef BEARING_TIMEOUT_EN
  // A watchdog expiry is routed through CHECK with a forced-invalid flag.
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_flag_q, tmo_flag_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q      <= 16'd0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign check_good = theta_ok(res_theta) && !tmo_flag_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign check_good     = theta_ok(res_theta);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      retry_q   <= 4'd0;
      err_q     <= 1'b0;
      theta_q   <= 9'd0;
      res_cnt_q <= 8'd0;
      for (int i = 0; i < 4; i++) res_q[i] <= 8'd0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
      theta_q   <= theta_d;
      res_cnt_q <= res_cnt_d;
      if (load_res) begin
        for (int i = 0; i < 4; i++) res_q[i] <= chan_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    err_d       = err_q;
    theta_d     = theta_q;
    res_cnt_d   = res_cnt_q;
    load_res    = 1'b0;
    latch_clear = 1'b0;
`ifdef BEARING_TIMEOUT_EN
    tmo_d       = tmo_q;
    tmo_flag_d  = tmo_flag_q;
`endif
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ARM;
            retry_d = 4'd0;
            err_d   = 1'b0;
          end
        end
        ST_ARM: begin
          latch_clear = 1'b1;
`ifdef BEARING_TIMEOUT_EN
          tmo_d       = 16'd0;
          tmo_flag_d  = 1'b0;
`endif
          state_d     = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (&chan_latched) begin
            state_d   = ST_RESOLVE;
            load_res  = 1'b1;
            res_cnt_d = 8'd0;
          end
`ifdef BEARING_TIMEOUT_EN
          else if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
            state_d    = ST_CHECK;
            tmo_flag_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
`endif
        end
        ST_RESOLVE: begin
          if (res_cnt_q == RES_LAST) state_d = ST_CHECK;
          else res_cnt_d = res_cnt_q + 8'd1;
        end
        ST_CHECK: begin
          if (check_good) begin
            theta_d = res_theta;
            state_d = ST_OUTPUT;
          end else if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_ARM;
          end else begin
            state_d = ST_FAIL;
          end
        end
        ST_OUTPUT: begin
          if (theta_ready) state_d = ST_IDLE;
        end
        ST_FAIL: begin
          err_d   = 1'b1;
          theta_d = INVALID_THETA;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign arm         = (state_q == ST_ARM);
  assign busy        = (state_q != ST_IDLE);
  assign theta_valid = (state_q == ST_OUTPUT);
  assign theta_out   = theta_q;
  assign err         = err_q;
  assign res_code_x1 = res_q[0];
  assign res_code_x2 = res_q[1];
  assign res_code_y1 = res_q[2];
  assign res_code_y2 = res_q[3];

endmodule

// File: doc/bearing_sequencer.md
BEARING_SEQUENCER -- requirements
Module: bearing_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clock and reset_n.
REQ-002 Parameter RES_LATENCY, default 2, SHALL be the clocks from res_code_* change to a stable res_theta.
REQ-003 Parameter TIMEOUT_CYCLES, default 16'd50000, SHALL be the CAPTURE watchdog limit.
REQ-004 Parameter MAX_RETRY, default 3, SHALL be the number of re-arms allowed before failure.
REQ-005 Ports SHALL be, in order:
- clock  in  1  system clock
- reset_n  in  1  async active-low reset
- start  in  1  request one bearing measurement (pulse)
- abort  in  1  synchronous return to IDLE
- code_valid  in  4  per-channel code strobe, bit order {y2,y1,x2,x1}
- code_x1, code_x2, code_y1, code_y2  in  8 each  delay codes from capture channels
- arm  out  1  one-cycle pulse that re-arms capture channels
- res_code_x1, res_code_x2, res_code_y1, res_code_y2  out  8 each  registered codes to the angle resolver
- res_theta  in  9  resolver angle; 9'h1FF means invalid
- theta_out  out  9  reported bearing, 0..359
- theta_valid  out  1  theta_out available
- theta_ready  in  1  consumer accepts theta_out
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky failure flag

Function
REQ-006 The FSM SHALL have the states IDLE, ARM, CAPTURE, RESOLVE, CHECK, OUTPUT and FAIL.
REQ-007 IDLE SHALL go to ARM on start; the retry count SHALL clear and err SHALL clear on that transition.
REQ-008 ARM SHALL assert arm for exactly one cycle, clear all four sticky latches and the timeout counter, then go to CAPTURE.
REQ-009 CAPTURE SHALL latch each channel's code on the first cycle its code_valid bit is high.
- Later strobes on an already-latched channel SHALL be ignored.
- When all four channels are latched, including the case where the last arrive simultaneously, the FSM SHALL go to RESOLVE on the next clock.
REQ-010 code_valid asserted during ARM SHALL be ignored.
REQ-011 On entry to RESOLVE, res_code_* SHALL load the latched codes and hold them stable until the next ARM.
- The FSM SHALL wait exactly RES_LATENCY cycles, then go to CHECK.
REQ-012 CHECK SHALL sample res_theta once. The result SHALL be valid if it is not 9'h1FF and is at most 9'd359.
- Valid: load theta_out and go to OUTPUT.
- Invalid, with retry count below MAX_RETRY: increment the retry count and go to ARM.
- Otherwise: go to FAIL.
REQ-013 OUTPUT SHALL hold theta_valid high and theta_out stable until theta_ready is high.
- On that same edge, theta_valid SHALL drop and the FSM SHALL return to IDLE.
- theta_ready while theta_valid is low SHALL have no effect.
REQ-014 FAIL SHALL set err, load theta_out with 9'h1FF, keep theta_valid low, and return to IDLE after one cycle.
REQ-015 start SHALL be ignored while busy is high.
REQ-016 abort SHALL force IDLE from any state on the next edge and deassert theta_valid and arm.
- abort SHALL have priority over start and over theta_ready when they coincide.
- err and theta_out SHALL keep their values on abort.
REQ-017 Start-to-theta_valid latency with no retries SHALL be 3 + capture wait + RES_LATENCY cycles.

Reset
REQ-018 When reset_n is low, the FSM SHALL be in IDLE, and every output (theta_out, res_code_*, theta_valid, arm, busy, err), every latch, the retry count and the timeout counter SHALL be 0.
REQ-019 A reset asserted mid-measurement SHALL discard that measurement; no output pulse SHALL follow the release of reset.

Configuration
REQ-020 With macro BEARING_TIMEOUT_EN defined, a 16-bit counter SHALL count in CAPTURE.
- When it reaches TIMEOUT_CYCLES-1 before all channels are latched, the FSM SHALL follow the invalid-result path of REQ-012: retry or FAIL.
REQ-021 With BEARING_TIMEOUT_EN undefined, no timeout counter SHALL exist and CAPTURE SHALL wait indefinitely; abort or reset is the only exit.

Structure
REQ-022 Package bearing_pkg SHALL hold the state enum, INVALID_THETA (9'h1FF) and THETA_MAX (9'd359).
REQ-023 Sub-module bearing_code_latch (8-bit sticky code register with a clear input and a latched flag) SHALL be instantiated four times.

Verification
REQ-024 Start, then codes x1=50, x2=0, y1=0, y2=10 strobed together -> arm pulse, res_code_* loaded; after 2 cycles res_theta=50 -> theta_valid with theta_out=50, held until theta_ready.
REQ-025 Strobes on x1 twice (first 60, then 70), then the other channels -> res_code_x1=60.
REQ-026 res_theta=9'h1FF on every CHECK -> four arm pulses total (initial plus MAX_RETRY=3), then err=1, theta_valid never high.
REQ-027 BEARING_TIMEOUT_EN with TIMEOUT_CYCLES=16 and only three channels strobed -> re-arm every 18 cycles; err after 3 retries. Without the macro -> stays in CAPTURE with busy=1.
REQ-028 abort during OUTPUT coinciding with theta_ready -> IDLE, theta_valid=0, busy=0; next start accepted immediately.
REQ-029 reset_n pulsed low during RESOLVE -> all outputs 0; no theta_valid after release.
